// File: rtl/playbus_datapath.sv
// PlayBus level-1 datapath: shared 8-bit bus, fixed ROM, RAM, switch buffer,
// LED latch, sticky bus-conflict flag and saturating RAM-write counter.
module playbus_datapath #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              ROMO,
  input  logic              RAMO,
  input  logic              RAMW,
  input  logic              SWBEN,
  input  logic              LEDLTCH,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] switches,
  output logic [DATA_W-1:0] bus,
  output logic [DATA_W-1:0] leds,
  output logic              conflict,
  output logic [DATA_W-1:0] wr_count
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] ram_q [DEPTH];
  logic [DATA_W-1:0] leds_q;
  logic [DATA_W-1:0] leds_d;
  logic [DATA_W-1:0] cnt_q;
  logic [DATA_W-1:0] cnt_d;
  logic              conf_q;
  logic              conf_d;
  logic [DATA_W-1:0] rom_word;
  logic [1:0]        n_drv;
  logic              multi;
  logic              wr_en;
  logic              led_en;

  assign n_drv = {1'b0, ROMO}
               + {1'b0, RAMO}
               + {1'b0, SWBEN};
  assign multi    = (n_drv >= 2'd2);
  assign wr_en    = RAMW & ~multi;
  assign led_en   = LEDLTCH & ~multi;
  assign rom_word = {addr, ~addr};

  // Idle bus floats high; contention reads as all-zero.
  always_comb begin
    bus = '0;
    unique case ({ROMO, RAMO, SWBEN})
      3'b000:  bus = '1;
      3'b100:  bus = rom_word;
      3'b010:  bus = ram_q[addr];
      3'b001:  bus = switches;
      default: bus = '0;
    endcase
  end

  always_comb begin
    leds_d = leds_q;
    cnt_d  = cnt_q;
    conf_d = conf_q | multi;
    if (led_en) leds_d = bus;
    if (wr_en && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < DEPTH; i++) ram_q[i] <= '0;
    end else if (wr_en) begin
      ram_q[addr] <= bus;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      leds_q <= '0;
      cnt_q  <= '0;
      conf_q <= 1'b0;
    end else begin
      leds_q <= leds_d;
      cnt_q  <= cnt_d;
      conf_q <= conf_d;
    end
  end

  assign leds     = leds_q;
  assign wr_count = cnt_q;
  assign conflict = conf_q;

endmodule

// File: tb/tb_playbus_datapath.sv
// Self-checking bench for playbus_datapath: reference model plus
// directed vectors with hand-computed literal expectations.
module tb_playbus_datapath;

  logic       clk = 1'b0;
  logic       n_reset;
  logic       ROMO, RAMO, RAMW, SWBEN, LEDLTCH;
  logic [3:0] addr;
  logic [7:0] switches;
  logic [7:0] bus, leds, wr_count;
  logic       conflict;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] m_ram [16];
  logic [7:0] m_leds;
  logic       m_conf;
  int         m_wr;

  always #5 clk = ~clk;

  playbus_datapath dut (
    .clk(clk), .n_reset(n_reset),
    .ROMO(ROMO), .RAMO(RAMO), .RAMW(RAMW),
    .SWBEN(SWBEN), .LEDLTCH(LEDLTCH),
    .addr(addr), .switches(switches),
    .bus(bus), .leds(leds),
    .conflict(conflict), .wr_count(wr_count)
  );

  function automatic int drivers();
    return int'(ROMO) + int'(RAMO) + int'(SWBEN);
  endfunction

  function automatic logic [7:0] model_bus();
    if (drivers() == 0) return 8'hFF;
    if (drivers() > 1) return 8'h00;
    if (ROMO) return {addr, ~addr};
    if (RAMO) return m_ram[addr];
    return switches;
  endfunction

  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < 16; i++) m_ram[i] <= 8'h00;
      m_leds <= 8'h00;
      m_conf <= 1'b0;
      m_wr   <= 0;
    end else if (drivers() > 1) begin
      m_conf <= 1'b1;
    end else begin
      if (RAMW) begin
        m_ram[addr] <= model_bus();
        if (m_wr < 255) m_wr <= m_wr + 1;
      end
      if (LEDLTCH) m_leds <= model_bus();
    end
  end

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("bus", bus, model_bus());
    chk("leds", leds, m_leds);
    chk("conflict", {7'd0, conflict}, {7'd0, m_conf});
    chk("wr_count", wr_count, 8'(m_wr));
  end

  task automatic drive(input logic ro, ra, rw, sw, ll,
                       input logic [3:0] a,
                       input logic [7:0] s);
    @(posedge clk);
    #1;
    ROMO = ro; RAMO = ra; RAMW = rw;
    SWBEN = sw; LEDLTCH = ll;
    addr = a; switches = s;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 4'd0, 8'h00);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    n_reset = 1'b0;
    ROMO = 0; RAMO = 0; RAMW = 0;
    SWBEN = 0; LEDLTCH = 0;
    addr = 4'd0; switches = 8'h00;
    #22;
    chk("rst_leds", leds, 8'h00);
    chk("rst_conf", {7'd0, conflict}, 8'h00);
    chk("rst_wr", wr_count, 8'h00);
    chk("rst_bus", bus, 8'hFF);
    @(negedge clk);
    n_reset = 1'b1;

    for (int a = 0; a < 16; a++) begin
      drive(0, 1, 0, 0, 0, 4'(a), 8'h00);
      settle();
      chk("ram_init", bus, 8'h00);
    end

    drive(1, 0, 0, 0, 1, 4'd3, 8'h00);
    settle();
    chk("rom3_bus", bus, 8'h3C);
    idle();
    settle();
    chk("rom3_leds", leds, 8'h3C);
    chk("rom3_wr", wr_count, 8'h00);
    drive(1, 0, 0, 0, 0, 4'd0, 8'h00);
    settle();
    chk("rom0", bus, 8'h0F);
    drive(1, 0, 0, 0, 0, 4'd15, 8'h00);
    settle();
    chk("rom15", bus, 8'hF0);

    drive(0, 0, 1, 1, 0, 4'd7, 8'hA5);
    settle();
    chk("sw_bus", bus, 8'hA5);
    drive(0, 1, 0, 0, 1, 4'd7, 8'h00);
    settle();
    chk("ram7_wr", wr_count, 8'h01);
    chk("ram7_bus", bus, 8'hA5);
    drive(0, 1, 0, 0, 0, 4'd6, 8'h00);
    settle();
    chk("ram7_leds", leds, 8'hA5);
    chk("ram6", bus, 8'h00);

    drive(0, 0, 1, 0, 0, 4'd9, 8'h00);
    drive(0, 1, 0, 0, 0, 4'd9, 8'h00);
    settle();
    chk("pullup_wr", bus, 8'hFF);
    chk("pullup_cnt", wr_count, 8'h02);
    drive(0, 1, 1, 0, 0, 4'd7, 8'h00);
    drive(0, 1, 0, 0, 0, 4'd7, 8'h00);
    settle();
    chk("wb_bus", bus, 8'hA5);
    chk("wb_cnt", wr_count, 8'h03);

    drive(1, 0, 1, 1, 1, 4'd7, 8'h33);
    settle();
    chk("conf_bus", bus, 8'h00);
    drive(0, 1, 0, 0, 0, 4'd7, 8'h00);
    settle();
    chk("conf_flag", {7'd0, conflict}, 8'h01);
    chk("conf_wr", wr_count, 8'h03);
    chk("conf_leds", leds, 8'hA5);
    chk("conf_ram", bus, 8'hA5);

    for (int i = 0; i < 300; i++)
      drive(0, 0, 1, 1, 0, 4'd1, 8'h11);
    idle();
    settle();
    chk("sat_wr", wr_count, 8'hFF);
    chk("sat_conf", {7'd0, conflict}, 8'h01);
    drive(0, 1, 0, 0, 0, 4'd1, 8'h00);
    settle();
    chk("sat_ram1", bus, 8'h11);

    drive(0, 0, 1, 1, 1, 4'd2, 8'h5A);
    drive(0, 1, 0, 0, 0, 4'd2, 8'h00);
    settle();
    chk("pre_rst_bus", bus, 8'h5A);
    chk("pre_rst_leds", leds, 8'h5A);
    n_reset = 1'b0;
    #1;
    chk("mid_leds", leds, 8'h00);
    chk("mid_wr", wr_count, 8'h00);
    chk("mid_conf", {7'd0, conflict}, 8'h00);
    chk("mid_ram2", bus, 8'h00);
    drive(0, 0, 1, 1, 1, 4'd2, 8'h77);
    settle();
    chk("rst_edge_wr", wr_count, 8'h00);
    chk("rst_edge_leds", leds, 8'h00);
    ROMO = 0; RAMO = 1; RAMW = 0;
    SWBEN = 0; LEDLTCH = 0;
    addr = 4'd2;
    n_reset = 1'b1;
    #1;
    chk("rst_edge_ram", bus, 8'h00);
    drive(0, 0, 1, 1, 0, 4'd4, 8'hC3);
    drive(0, 1, 0, 0, 0, 4'd4, 8'h00);
    settle();
    chk("post_rst_ram", bus, 8'hC3);
    chk("post_rst_wr", wr_count, 8'h01);
    idle();
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/playbus_datapath.md
# playbus_datapath

Level 1 PlayBus datapath: the stage directly downstream of the PlayBus controller, consuming its ROMO, RAMO, RAMW, SWBEN and LEDLTCH strobes. It holds an 8-bit shared bus, a fixed 16x8 ROM, a 16x8 RAM, a switch buffer and an LED output latch. It also keeps a sticky bus-conflict flag and a saturating RAM-write counter for debug and verification.

## Interface
- DATA_W, 8, bus/ROM/RAM/LED width (only 8 is supported)
- ADDR_W, 4, address width; memory depth = 2**ADDR_W = 16
- clk  input  1  system clock, all state updates on rising edge
- n_reset  input  1  asynchronous active-low reset
- ROMO  input  1  ROM output enable onto bus
- RAMO  input  1  RAM output enable onto bus
- RAMW  input  1  RAM write strobe
- SWBEN  input  1  switch buffer enable onto bus
- LEDLTCH  input  1  LED latch strobe
- addr  input  4  ROM/RAM address, sampled combinationally
- switches  input  8  external switch values
- bus  output  8  current shared-bus value (observable)
- leds  output  8  LED latch contents
- conflict  output  1  sticky: set when >1 bus driver was enabled
- wr_count  output  8  number of RAM writes performed, saturating

## Operation
- Drivers: ROMO, RAMO, SWBEN. Number of drivers enabled = n.
- Bus value, combinational in the same cycle:
  - n=0: 8'hFF (pull-up).
  - n=1: ROMO gives rom[addr]; RAMO gives ram[addr]; SWBEN gives switches.
  - n>=2: 8'h00.
- ROM contents fixed: rom[a] = {a, ~a} (e.g. a=3 gives 8'h3C, a=0 gives 8'h0F, a=15 gives 8'hF0). Read-only, combinational.
- RAM: combinational read of ram[addr]; synchronous write ram[addr] <= bus on a rising edge with RAMW=1 and n<=1.
  - RAMW with n=0 writes 8'hFF.
  - RAMW with RAMO writes back the current value (legal no-op).
- LEDs: leds <= bus on a rising edge with LEDLTCH=1 and n<=1. Otherwise they hold.
- conflict: set at a rising edge where n>=2. It stays set until reset.
- Suppression: while n>=2, RAMW and LEDLTCH have no effect and wr_count does not change.
- wr_count: increments on each effective RAM write and saturates at 8'hFF.
- RAMW and LEDLTCH in the same cycle: both take effect using the same bus value.

## Timing
- Reset (n_reset=0, asynchronous, immediate):
  - leds=8'h00, conflict=0, wr_count=8'h00, all RAM words = 8'h00.
  - bus stays combinational throughout.
- Deassertion of reset is synchronised by the system. The first write is accepted on the first rising edge with n_reset=1.
- Latency:
  - bus follows enables, addr and switches with zero cycles (combinational).
  - leds, RAM contents, wr_count and conflict update one edge after the qualifying strobe.
  - A RAM read of a just-written address returns the new data in the cycle after the write edge.
- Reset asserted mid-operation: all state clears at once, and a strobe present on the edge coinciding with reset is ignored.
- addr changes have no sequential effect. Only the value present at the write edge matters.
- No handshake: every strobe is a single-cycle command. A strobe held for k cycles acts k times, so wr_count increments by k.

## Test plan
- Reset: hold n_reset=0 with all strobes 0 -> leds=00, conflict=0, wr_count=00, bus=FF. Release, then RAMO=1 at every addr -> bus=00.
- ROM to LED: addr=3, ROMO=1, LEDLTCH=1 for one edge -> bus=3C during the cycle, leds=3C after the edge, wr_count=00.
- Switch to RAM to LED: switches=A5, addr=7, SWBEN=1 with RAMW=1 for one edge -> wr_count=01. Then RAMO=1 with LEDLTCH=1 -> leds=A5. Other addresses still read 00.
- Conflict: ROMO=1 and SWBEN=1 with RAMW=1 and LEDLTCH=1 for one edge -> bus=00, conflict=1, leds and RAM unchanged, wr_count unchanged. Conflict remains 1 until reset.
- Saturation: SWBEN=1 and RAMW=1 held for 300 cycles -> wr_count reaches FF and stays FF.
- Reset mid-operation: write 5A to addr 2, then pulse n_reset low between edges -> leds, wr_count and RAM[2] read 00 immediately.
